seq_detector: RTL and testbench

Parametrised serial bit-pattern detector with a runtime-programmable pattern (1..MAX_LEN bits), selectable overlapping or non-overlapping matching, a saturating match counter and a debug fill-level output. It generalises the fixed 3-bit "101" detector FSM. It sits on a single-bit serial stream, with a valid qualifier, and raises a one-cycle match pulse registered after the completing bit. After reset it behaves exactly as an overlapping "101" detector.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_detector_sat_counter.sv | 28 ++
 rtl/seq_detector.sv | 95 +++++++++
 tb/tb_seq_detector.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: default sizes,
// the power-on pattern and the active-configuration record.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 16;
  localparam int LEN_W_DEF   = $clog2(MAX_LEN_DEF + 1);

  // After reset the detector behaves as an overlapping "101" detector.
  localparam logic [MAX_LEN_DEF-1:0] RESET_PATTERN = MAX_LEN_DEF'('b101);
  localparam logic [LEN_W_DEF-1:0]   RESET_LEN     = LEN_W_DEF'(3);

  // Active configuration; field widths set the widest supported pattern.
  typedef struct packed {
    logic [MAX_LEN_DEF-1:0] pattern;
    logic [LEN_W_DEF-1:0]   len;
    logic                   overlap;
  } cfg_t;

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating event counter. A clear coinciding with an increment
// yields 1 so the event arriving on the clearing edge is kept.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Count events, holding at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= W'(inc);
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with a runtime-programmable pattern,
// overlapping / non-overlapping matching and a saturating match counter.
// The pattern's bit [len-1] is the oldest bit, bit [0] the newest.
// MAX_LEN must not exceed the package's MAX_LEN_DEF.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = MAX_LEN_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clear,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   fill_out
);

  cfg_t               cfg;
  logic [MAX_LEN-1:0] hist, hist_nxt, shifted, mask, pat;
  logic [LEN_W-1:0]   fill, fill_nxt, len;
  logic               match;

  // A zero length would match nothing meaningful; over-long lengths
  // cannot be held in the history register.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0) return LEN_W'(1);
    if (int'(l) > MAX_LEN) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  // Masked compare of the newest len bits and next history/fill.
  always_comb begin
    pat     = MAX_LEN'(cfg.pattern);
    len     = LEN_W'(cfg.len);
    shifted = {hist[MAX_LEN-2:0], in};
    mask    = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    match = in_valid && !cfg_load
         && (int'(fill) + 1 >= int'(len))
         && (((shifted ^ pat) & mask) == '0);
    hist_nxt = hist;
    fill_nxt = fill;
    if (cfg_load) begin
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (in_valid) begin
      hist_nxt = shifted;
      if (match && !cfg.overlap) begin
        fill_nxt = '0;
      end else if (int'(fill) < MAX_LEN) begin
        fill_nxt = fill + 1'b1;
      end
    end
  end

  // Configuration, history, fill level and the registered match pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      cfg  <= '{pattern: RESET_PATTERN, len: RESET_LEN, overlap: 1'b1};
      hist <= '0;
      fill <= '0;
      out  <= 1'b0;
    end else begin
      if (cfg_load) begin
        cfg <= '{pattern: MAX_LEN_DEF'(cfg_pattern),
                 len:     LEN_W_DEF'(clamp_len(cfg_len)),
                 overlap: cfg_overlap};
      end
      hist <= hist_nxt;
      fill <= fill_nxt;
      out  <= match;
    end
  end

  assign fill_out = fill;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (match),
    .clr   (cnt_clear),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector.sv
// Randomised and directed bench for seq_detector. Two instances share the
// stimulus: default counter width and a 2-bit counter for saturation.
module tb_seq_detector;

  localparam int ML = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in = 1'b0;
  logic        cfg_load = 1'b0;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_overlap = 1'b0;
  logic        cnt_clear = 1'b0;

  logic        out_a, out_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [3:0]  fill_a, fill_b;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  // Reference state: the valid bits seen since the last restart.
  bit     q[$];
  bit [7:0] m_pat;
  int     m_len;
  bit     m_ovl;
  longint raw;
  bit     exp_out;

  always #5 clock = ~clock;

  seq_detector u_dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in(in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
    .out(out_a), .match_count(cnt_a), .fill_out(fill_a)
  );

  seq_detector #(.MAX_LEN(8), .CNT_W(2)) u_dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in(in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
    .out(out_b), .match_count(cnt_b), .fill_out(fill_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint min_l(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  // One clock edge of the specified behaviour, applied to the queue model.
  task automatic model_edge();
    bit m;
    int l;
    if (reset) begin
      q.delete();
      m_pat = 8'b101; m_len = 3; m_ovl = 1'b1;
      raw = 0; exp_out = 1'b0;
      return;
    end
    m = 1'b0;
    if (cfg_load) begin
      l = int'(cfg_len);
      if (l == 0) l = 1;
      if (l > ML) l = ML;
      m_pat = cfg_pattern; m_len = l; m_ovl = cfg_overlap;
      q.delete();
    end else if (in_valid) begin
      q.push_back(in);
      if (q.size() >= m_len) begin
        m = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (q[q.size() - 1 - i] != m_pat[i]) m = 1'b0;
      end
      if (m && !m_ovl) q.delete();
      while (q.size() > ML) void'(q.pop_front());
    end
    raw = cnt_clear ? longint'(m) : raw + longint'(m);
    exp_out = m;
  endtask

  // Drive one cycle, advance the model, then compare all outputs.
  task automatic step(input bit rst, input bit ld, input bit clr, input bit v, input bit b);
    reset = rst; cfg_load = ld; cnt_clear = clr; in_valid = v; in = b;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    pulses += int'(out_a);
    check_eq("out_a",  64'(out_a),  64'(exp_out));
    check_eq("out_b",  64'(out_b),  64'(exp_out));
    check_eq("cnt_a",  64'(cnt_a),  64'(min_l(raw, 65535)));
    check_eq("cnt_b",  64'(cnt_b),  64'(min_l(raw, 3)));
    check_eq("fill_a", 64'(fill_a), 64'(q.size()));
  endtask

  task automatic load(input bit [7:0] p, input bit [3:0] l, input bit o, input bit clr);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    step(1'b0, 1'b1, clr, 1'b1, 1'b1);
  endtask

  initial begin
    bit [4:0] s1;
    bit [6:0] s2;
    int exp_b[5];

    @(negedge clock);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_out",  64'(out_a),  64'd0);
    check_eq("rst_cnt",  64'(cnt_a),  64'd0);
    check_eq("rst_fill", 64'(fill_a), 64'd0);

    // Default overlapping "101": 1,0,1,0,1
    s1 = 5'b10101; pulses = 0;
    for (int i = 4; i >= 0; i--) step(1'b0, 1'b0, 1'b0, 1'b1, s1[i]);
    check_eq("s1_pulses", 64'(pulses), 64'd2);
    check_eq("s1_count",  64'(cnt_a),  64'd2);
    check_eq("s1_fill",   64'(fill_a), 64'd5);

    // 1101 non-overlapping, then overlapping, on 1,1,0,1,1,0,1
    s2 = 7'b1101101;
    for (int pass = 0; pass < 2; pass++) begin
      load(8'b1101, 4'd4, pass[0], 1'b0);
      check_eq("ld_fill", 64'(fill_a), 64'd0);
      pulses = 0;
      for (int i = 6; i >= 0; i--) begin
        step(1'b0, 1'b0, 1'b0, 1'b1, s2[i]);
        if (i == 3) check_eq("s2_4th", 64'(out_a), 64'd1);
      end
      check_eq(pass ? "s3_pulses" : "s2_pulses", 64'(pulses), pass ? 64'd2 : 64'd1);
    end

    // "101" spanning an idle gap
    load(8'b101, 4'd3, 1'b1, 1'b0);
    pulses = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("gap_fill", 64'(fill_a), 64'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("gap_out",    64'(out_a), 64'd1);
    check_eq("gap_pulses", 64'(pulses), 64'd1);

    // Pattern "1": 2-bit counter saturates at 3; clear with a match gives 1
    load(8'b1, 4'd1, 1'b1, 1'b1);
    exp_b = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_eq("sat_cnt_b", 64'(cnt_b), 64'(exp_b[i]));
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("clr_inc_b", 64'(cnt_b), 64'd1);
    check_eq("clr_inc_a", 64'(cnt_a), 64'd1);

    // Partial 1,0 discarded by reset, and by reloading the same pattern
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) load(8'b101, 4'd3, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (pass == 0) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      else           load(8'b101, 4'd3, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_eq("restart_out",  64'(out_a),  64'd0);
      check_eq("restart_fill", 64'(fill_a), 64'd1);
    end

    // Length clamping: 0 behaves as 1, 12 behaves as 8
    load(8'hA5, 4'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("len0_out", 64'(out_a), 64'd1);
    load(8'hA5, 4'd12, 1'b0, 1'b0);
    s1 = '0;
    for (int i = 7; i >= 0; i--) step(1'b0, 1'b0, 1'b0, 1'b1, bit'(8'hA5 >> i));
    check_eq("len12_out", 64'(out_a), 64'd1);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit ld, rst, clr;
      r = int'($urandom_range(0, 99));
      rst = (r < 2);
      ld  = (r >= 2 && r < 7);
      clr = ($urandom_range(0, 99) < 4);
      cfg_pattern = 8'($urandom);
      cfg_len     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(1, 4));
      cfg_overlap = 1'($urandom);
      step(rst, ld, clr, ($urandom_range(0, 9) < 8), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
